// File: rtl/trb_mem_arbiter_pkg.sv
// Shared types and sizing for the trace-memory arbiter: slot states and the
// default trace RAM geometry.
package trb_mem_arbiter_pkg;

    localparam int TRB_WIDTH          = 16;
    localparam int TRB_ADDR_WIDTH     = 8;
    localparam int TRB_MEM_RD_LATENCY = 1;

    // One-hot encoding keeps each state decode a single flop.
    typedef enum logic [4:0] {
        IDLE = 5'b00001,
        PRE  = 5'b00010,
        RD   = 5'b00100,
        WR   = 5'b01000,
        HOST = 5'b10000
    } arb_state_t;

endpackage

// File: rtl/trb_mem_arbiter.sv
// Time-slot scheduler for the single-port trace RAM: runs Logger read/write
// rounds (PRE, RD, WR) and inserts a host slot between rounds on request.
module trb_mem_arbiter
    import trb_mem_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = TRB_WIDTH,
    parameter int ADDR_WIDTH = TRB_ADDR_WIDTH
) (
    input  logic                  CLK_I,
    input  logic                  RST_I,
    input  logic                  ENABLE_I,
    output logic                  RW_TURN_O,
    output logic                  WRITE_ALLOW_O,
    output logic                  READ_ALLOW_O,
    input  logic                  LOG_WRITE_I,
    input  logic [ADDR_WIDTH-1:0] LOG_WPTR_I,
    input  logic [DATA_WIDTH-1:0] LOG_WDATA_I,
    input  logic [ADDR_WIDTH-1:0] LOG_RPTR_I,
    output logic [DATA_WIDTH-1:0] LOG_RDATA_O,
    input  logic                  HOST_REQ_I,
    input  logic                  HOST_WE_I,
    input  logic [ADDR_WIDTH-1:0] HOST_ADDR_I,
    input  logic [DATA_WIDTH-1:0] HOST_WDATA_I,
    output logic                  HOST_GNT_O,
    output logic                  HOST_RVALID_O,
    output logic [DATA_WIDTH-1:0] HOST_RDATA_O,
    output logic                  MEM_EN_O,
    output logic                  MEM_WE_O,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR_O,
    output logic [DATA_WIDTH-1:0] MEM_WDATA_O,
    input  logic [DATA_WIDTH-1:0] MEM_RDATA_I
);

    arb_state_t r_state;
    arb_state_t w_state_nxt;

    logic                  w_gnt;
    logic                  w_mem_en;
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;
    logic                  w_host_rd;

    logic                  r_rd_vld_p0;
    logic                  r_rd_vld_p1;
    logic [DATA_WIDTH-1:0] r_host_rdata_p1;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt         = 1'b0;
        w_mem_en      = 1'b0;
        w_mem_we      = 1'b0;
        w_mem_addr    = '0;
        w_mem_wdata   = '0;
        RW_TURN_O     = 1'b0;
        WRITE_ALLOW_O = 1'b0;
        READ_ALLOW_O  = 1'b0;
        LOG_RDATA_O   = '0;
        unique case (r_state)
            IDLE: begin
                // Host-only mode serves a request every cycle; the reset
                // gate keeps the grant quiet while RST_I is still high.
                if (HOST_REQ_I && !RST_I) begin
                    w_gnt       = 1'b1;
                    w_mem_en    = 1'b1;
                    w_mem_we    = HOST_WE_I;
                    w_mem_addr  = HOST_ADDR_I;
                    w_mem_wdata = HOST_WDATA_I;
                end
                w_state_nxt = ENABLE_I ? PRE : IDLE;
            end
            PRE: begin
                w_mem_en    = 1'b1;
                w_mem_addr  = LOG_RPTR_I;
                w_state_nxt = RD;
            end
            RD: begin
                READ_ALLOW_O = 1'b1;
                LOG_RDATA_O  = MEM_RDATA_I;
                w_state_nxt  = WR;
            end
            WR: begin
                RW_TURN_O     = 1'b1;
                WRITE_ALLOW_O = 1'b1;
                w_mem_en      = LOG_WRITE_I;
                w_mem_we      = LOG_WRITE_I;
                w_mem_addr    = LOG_WPTR_I;
                w_mem_wdata   = LOG_WDATA_I;
                if (!ENABLE_I) begin
                    w_state_nxt = IDLE;
                end else if (HOST_REQ_I) begin
                    w_state_nxt = HOST;
                end else begin
                    w_state_nxt = PRE;
                end
            end
            HOST: begin
                w_gnt       = 1'b1;
                w_mem_en    = 1'b1;
                w_mem_we    = HOST_WE_I;
                w_mem_addr  = HOST_ADDR_I;
                w_mem_wdata = HOST_WDATA_I;
                w_state_nxt = ENABLE_I ? PRE : IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign HOST_GNT_O  = w_gnt;
    assign MEM_EN_O    = w_mem_en;
    assign MEM_WE_O    = w_mem_we;
    assign MEM_ADDR_O  = w_mem_addr;
    assign MEM_WDATA_O = w_mem_wdata;

    assign w_host_rd = w_gnt & ~w_mem_we;

    // Stage p0: RAM is returning the granted word this cycle.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_rd_vld_p0 <= 1'b0;
            r_rd_vld_p1 <= 1'b0;
        end else begin
            r_rd_vld_p0 <= w_host_rd;
            r_rd_vld_p1 <= r_rd_vld_p0;
        end
    end

    // Stage p1: captured word is presented alongside RVALID and held.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_host_rdata_p1 <= '0;
        end else if (r_rd_vld_p0) begin
            r_host_rdata_p1 <= MEM_RDATA_I;
        end
    end

    assign HOST_RVALID_O = r_rd_vld_p1;
    assign HOST_RDATA_O  = r_host_rdata_p1;

endmodule

// File: tb/tb_trb_mem_arbiter.sv
// Directed bench for trb_mem_arbiter with a behavioural single-port RAM and
// queue-based scoreboards for Logger reads, host reads and RAM writes.
module tb_trb_mem_arbiter;

    localparam int DW = 16;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          RST_I;
    logic          ENABLE_I;
    logic          RW_TURN_O, WRITE_ALLOW_O, READ_ALLOW_O;
    logic          LOG_WRITE_I;
    logic [AW-1:0] LOG_WPTR_I, LOG_RPTR_I;
    logic [DW-1:0] LOG_WDATA_I, LOG_RDATA_O;
    logic          HOST_REQ_I, HOST_WE_I;
    logic [AW-1:0] HOST_ADDR_I;
    logic [DW-1:0] HOST_WDATA_I, HOST_RDATA_O;
    logic          HOST_GNT_O, HOST_RVALID_O;
    logic          MEM_EN_O, MEM_WE_O;
    logic [AW-1:0] MEM_ADDR_O;
    logic [DW-1:0] MEM_WDATA_O, MEM_RDATA_I;

    logic [DW-1:0] ram [0:(1<<AW)-1];

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0]    q_log  [$];
    logic [DW-1:0]    q_host [$];
    logic [AW+DW-1:0] q_wr   [$];

    always #5 clk = ~clk;

    trb_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .CLK_I         (clk),
        .RST_I         (RST_I),
        .ENABLE_I      (ENABLE_I),
        .RW_TURN_O     (RW_TURN_O),
        .WRITE_ALLOW_O (WRITE_ALLOW_O),
        .READ_ALLOW_O  (READ_ALLOW_O),
        .LOG_WRITE_I   (LOG_WRITE_I),
        .LOG_WPTR_I    (LOG_WPTR_I),
        .LOG_WDATA_I   (LOG_WDATA_I),
        .LOG_RPTR_I    (LOG_RPTR_I),
        .LOG_RDATA_O   (LOG_RDATA_O),
        .HOST_REQ_I    (HOST_REQ_I),
        .HOST_WE_I     (HOST_WE_I),
        .HOST_ADDR_I   (HOST_ADDR_I),
        .HOST_WDATA_I  (HOST_WDATA_I),
        .HOST_GNT_O    (HOST_GNT_O),
        .HOST_RVALID_O (HOST_RVALID_O),
        .HOST_RDATA_O  (HOST_RDATA_O),
        .MEM_EN_O      (MEM_EN_O),
        .MEM_WE_O      (MEM_WE_O),
        .MEM_ADDR_O    (MEM_ADDR_O),
        .MEM_WDATA_O   (MEM_WDATA_O),
        .MEM_RDATA_I   (MEM_RDATA_I)
    );

    // Single-port RAM with one-cycle synchronous read.
    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
        ram[5] = 16'h00A5;
        MEM_RDATA_I = '0;
    end

    always @(posedge clk) begin
        if (MEM_EN_O) begin
            if (MEM_WE_O) ram[MEM_ADDR_O] <= MEM_WDATA_O;
            else          MEM_RDATA_I     <= ram[MEM_ADDR_O];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a response.
    always @(negedge clk) begin
        if (!RST_I) begin
            if (READ_ALLOW_O) begin
                if (q_log.size() == 0) chk("log_read_unexpected", 32'(READ_ALLOW_O), 0);
                else                   chk("log_rdata", 32'(LOG_RDATA_O), 32'(q_log.pop_front()));
            end
            if (HOST_RVALID_O) begin
                if (q_host.size() == 0) chk("host_rvalid_unexpected", 32'(HOST_RVALID_O), 0);
                else                    chk("host_rdata", 32'(HOST_RDATA_O), 32'(q_host.pop_front()));
            end
            if (MEM_EN_O && MEM_WE_O) begin
                if (q_wr.size() == 0) chk("mem_write_unexpected", 32'(MEM_WE_O), 0);
                else                  chk("mem_write_addr_data", 32'({MEM_ADDR_O, MEM_WDATA_O}),
                                          32'(q_wr.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [2:0] exp_turn;
        logic [2:0] exp_ren;
        logic [2:0] exp_men;
        logic [3:0] h_gnt;
        logic [3:0] h_turn;
        logic [3:0] h_we;
        logic [3:0] h_en;
        exp_turn = 3'b100;
        exp_ren  = 3'b010;
        exp_men  = 3'b001;
        h_gnt    = 4'b1000;
        h_turn   = 4'b0100;
        h_we     = 4'b0100;
        h_en     = 4'b1101;

        RST_I = 1'b1; ENABLE_I = 1'b0;
        LOG_WRITE_I = 1'b0; LOG_WPTR_I = '0; LOG_WDATA_I = '0; LOG_RPTR_I = '0;
        HOST_REQ_I = 1'b0; HOST_WE_I = 1'b0; HOST_ADDR_I = '0; HOST_WDATA_I = '0;

        repeat (2) @(posedge clk);
        at_neg();
        chk("reset_mem_en",     32'(MEM_EN_O), 0);
        chk("reset_rw_turn",    32'(RW_TURN_O), 0);
        chk("reset_gnt",        32'(HOST_GNT_O), 0);
        chk("reset_rvalid",     32'(HOST_RVALID_O), 0);
        chk("reset_host_rdata", 32'(HOST_RDATA_O), 0);
        chk("reset_read_allow", 32'(READ_ALLOW_O), 0);

        step();
        RST_I = 1'b0;
        step();
        ENABLE_I = 1'b1; LOG_RPTR_I = 8'd5;
        q_log.push_back(16'h00A5);
        q_log.push_back(16'h00A5);
        at_neg();
        chk("idle_mem_en", 32'(MEM_EN_O), 0);

        // Two plain rounds: PRE, RD, WR, PRE, RD, WR.
        for (int i = 0; i < 6; i++) begin
            at_neg();
            chk("round_rw_turn",     32'(RW_TURN_O),     32'(exp_turn[i % 3]));
            chk("round_read_allow",  32'(READ_ALLOW_O),  32'(exp_ren[i % 3]));
            chk("round_write_allow", 32'(WRITE_ALLOW_O), 32'(exp_turn[i % 3]));
            chk("round_mem_en",      32'(MEM_EN_O),      32'(exp_men[i % 3]));
            if (i % 3 == 0) chk("pre_addr", 32'(MEM_ADDR_O), 5);
        end

        // Round with Logger write to 9 and a host read of 9 raised during PRE.
        step();
        LOG_WRITE_I = 1'b1; LOG_WPTR_I = 8'd9; LOG_WDATA_I = 16'h003C;
        HOST_REQ_I = 1'b1; HOST_WE_I = 1'b0; HOST_ADDR_I = 8'd9;
        q_log.push_back(16'h00A5);
        q_wr.push_back({8'd9, 16'h003C});
        q_host.push_back(16'h003C);
        for (int i = 0; i < 4; i++) begin
            at_neg();
            chk("hround_gnt",     32'(HOST_GNT_O), 32'(h_gnt[i]));
            chk("hround_rw_turn", 32'(RW_TURN_O),  32'(h_turn[i]));
            chk("hround_mem_we",  32'(MEM_WE_O),   32'(h_we[i]));
            chk("hround_mem_en",  32'(MEM_EN_O),   32'(h_en[i]));
            if (i == 3) chk("host_slot_addr", 32'(MEM_ADDR_O), 9);
        end

        // Next round: ENABLE drops during RD, WR still runs, then IDLE.
        step();
        HOST_REQ_I = 1'b0; LOG_WRITE_I = 1'b0;
        q_log.push_back(16'h00A5);
        step();
        ENABLE_I = 1'b0;
        at_neg();
        chk("drop_rd_read_allow", 32'(READ_ALLOW_O), 1);
        at_neg();
        chk("drop_wr_rw_turn",     32'(RW_TURN_O), 1);
        chk("drop_wr_write_allow", 32'(WRITE_ALLOW_O), 1);
        at_neg();
        chk("drop_idle_rw_turn", 32'(RW_TURN_O), 0);
        chk("drop_idle_mem_en",  32'(MEM_EN_O), 0);

        // Host-only mode: write 3, read 3, read 9 on consecutive cycles.
        step();
        HOST_REQ_I = 1'b1; HOST_WE_I = 1'b1; HOST_ADDR_I = 8'd3; HOST_WDATA_I = 16'h0011;
        q_wr.push_back({8'd3, 16'h0011});
        at_neg();
        chk("b2b_gnt_wr", 32'(HOST_GNT_O), 1);
        step();
        HOST_WE_I = 1'b0;
        q_host.push_back(16'h0011);
        at_neg();
        chk("b2b_gnt_rd3", 32'(HOST_GNT_O), 1);
        step();
        HOST_ADDR_I = 8'd9;
        q_host.push_back(16'h003C);
        at_neg();
        chk("b2b_gnt_rd9", 32'(HOST_GNT_O), 1);
        step();
        HOST_REQ_I = 1'b0;
        at_neg();
        chk("b2b_gnt_off", 32'(HOST_GNT_O), 0);
        repeat (3) at_neg();
        chk("host_rdata_hold", 32'(HOST_RDATA_O), 32'h3C);

        // Reset asserted between GNT and RVALID of a host read.
        step();
        HOST_REQ_I = 1'b1; HOST_WE_I = 1'b0; HOST_ADDR_I = 8'd5;
        at_neg();
        chk("rst_read_gnt", 32'(HOST_GNT_O), 1);
        step();
        RST_I = 1'b1;
        #1;
        chk("rst_gnt_masked", 32'(HOST_GNT_O), 0);
        chk("rst_rdata_clr",  32'(HOST_RDATA_O), 0);
        chk("rst_mem_en",     32'(MEM_EN_O), 0);
        at_neg();
        chk("rst_rvalid", 32'(HOST_RVALID_O), 0);
        HOST_REQ_I = 1'b0;
        step();
        RST_I = 1'b0;
        for (int i = 0; i < 4; i++) begin
            at_neg();
            chk("post_rst_rvalid", 32'(HOST_RVALID_O), 0);
        end

        chk("log_queue_drained",  32'(q_log.size()), 0);
        chk("host_queue_drained", 32'(q_host.size()), 0);
        chk("wr_queue_drained",   32'(q_wr.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
